rpn_calculator: RTL and testbench
=================================

# rpn_calculator

Parametrised reverse-Polish successor to the single-register calculator datapath. It consumes debounced single-button events from `sanitize_buttons`, builds decimal operands in an entry register, and keeps operands on a `StackDepth`-deep stack. Arithmetic is delegated to the existing `alu` over its ready/valid handshake. The block sits between `sanitize_buttons` and the display/segment logic, and replaces the controller + `display`/`upper` register pair.

## Interface
Parameters:
- `NumDigits`, 8: maximum decimal digits accepted per entered operand.
- `StackDepth`, 4: number of stack entries (≥2).

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `active_button_i`, in, `calc_pkg::active_button_t`: button code, valid when `new_input_i`=1.
- `new_input_i`, in, 1: one-cycle pulse per press.
- `display_o`, out, `calc_pkg::num_t`: value to show.
- `depth_o`, out, `$clog2(StackDepth+1)`: current stack occupancy.
- `busy_o`, out, 1: ALU operation in flight.
- `error_o`, out, 1: sticky overflow/underflow flag.
- `alu_left_o`, out, `calc_pkg::num_t`: left ALU operand.
- `alu_right_o`, out, `calc_pkg::num_t`: right ALU operand.
- `alu_op_o`, out, `calc_pkg::op_t`: ALU operation.
- `alu_in_valid_o`, out, 1: ALU input handshake, valid.
- `alu_in_ready_i`, in, 1: ALU input handshake, ready.
- `alu_result_i`, in, `calc_pkg::num_t`: ALU result.
- `alu_out_valid_i`, in, 1: ALU output handshake, valid.
- `alu_out_ready_o`, out, 1: ALU output handshake, ready.

## Operation
State machine states: IDLE, ALU_REQ, ALU_WAIT, ERROR.

Button handling applies only in IDLE, and only when `new_input_i`=1. Presses in ALU_REQ or ALU_WAIT are dropped, CLEAR included.
- DIGIT d, not entering: entry=d, digit count=1, entering=1.
- DIGIT d, entering, count<NumDigits: entry=entry*10+d, count+1.
- DIGIT d, entering, count=NumDigits: press is ignored.
- ENTER, entering: push entry, entering=0.
- ENTER, not entering, depth≥1: duplicate top of stack.
- ENTER, not entering, depth=0: no-op.
- ADD/SUB/MUL/DIV:
  - If entering, implicitly push entry first and clear entering.
  - If depth is then <2, enter ERROR (underflow).
  - Otherwise pop Y (top) and X (next). Drive left=X, right=Y, op=mapped op, and go to ALU_REQ.
- DROP: pop if depth≥1, else no-op. Clears entering without pushing.
- SWAP: exchange the top two entries if depth≥2, else no-op.
- CLEAR: empty the stack, entry=0, entering=0.
- Overflow: any push while depth=StackDepth enters ERROR. The stack is left unchanged.

ALU handshake:
- ALU_REQ: `alu_in_valid_o`=1. Operands and op are held stable until `alu_in_ready_i`=1, then go to ALU_WAIT.
- ALU_WAIT: `alu_out_ready_o`=1. On `alu_out_valid_i`=1, push `alu_result_i` and return to IDLE. Space is guaranteed because two entries were popped.

ERROR:
- `error_o`=1; all buttons except CLEAR are ignored.
- CLEAR performs the clear described above and returns to IDLE.

Display:
- `display_o` = entry when entering.
- Otherwise `display_o` = top of stack, or 0 when the stack is empty.

Arithmetic and width rules:
- Entry arithmetic is unsigned in `num_t` width.
- The package guarantees `num_t` holds 10^NumDigits−1 plus sign.
- ALU results are stored unmodified (may be negative).

## Timing
- Reset values: state IDLE, stack empty, `depth_o`=0, entry=0, entering=0.
- All outputs are 0 in reset, including `display_o`, `busy_o`, `error_o`, `alu_in_valid_o` and `alu_out_ready_o`. The ALU operand and op outputs are also 0.
- All outputs are registered. A press in cycle N is reflected on `display_o`/`depth_o`/`error_o` in cycle N+1.
- An operator press in cycle N raises `alu_in_valid_o` in N+1.
- A result accepted in cycle M appears on `display_o` in M+1, with `busy_o` falling in M+1.
- `busy_o`=1 exactly in ALU_REQ and ALU_WAIT.
- Valid/ready are never combinationally dependent on each other.
- Reset mid-handshake aborts immediately. The ALU shares the same reset, so no stale result is left behind.

## Structure
- `calc_pkg` gains:
  - `StackDepth` default;
  - `depth_t`;
  - `rpn_state_e`;
  - DROP/SWAP/ENTER codes in `active_button_t`;
  - a button→`op_t` mapping function.
- Sub-module `num_stack`:
  - flop-array LIFO;
  - push/pop/swap/clear controls;
  - exposes top, next and depth;
  - asserts nothing on illegal ops (the FSM gates them).

## Test plan
- 3, ENTER, 4, ADD → ALU sees left=3, right=4, op=ADD. Respond 7 → display 7, depth 1, busy low.
- NumDigits=8: nine presses of 9 → display 99999999; ninth press ignored.
- StackDepth=4: 1 ENTER 2 ENTER 3 ENTER 4 ENTER, then 5 ENTER → error_o=1, depth 4. Digit ignored afterwards. CLEAR → depth 0, error 0.
- Empty stack: 5, SUB → underflow, error_o=1, no ALU request.
- Hold `alu_in_ready_i`=0 for 10 cycles while pressing 7 and CLEAR → operands stable, presses dropped. Release → completes normally.
- Assert `rst_ni`=0 while in ALU_WAIT → all outputs 0 next edge-free cycle, state IDLE, depth 0.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator datapath.
//   num_t            signed operand/result word (holds 10^8-1 plus sign)
//   depth_t          stack occupancy for the default stack depth
//   active_button_t  debounced button codes; digits 0..9 occupy codes 0..9
//   op_t             ALU operation codes
//   rpn_state_e      rpn_calculator control states
//   button_to_op()   maps an operator button to its ALU operation
//   is_digit()       true for the ten digit buttons
package calc_pkg;

  localparam int NumDigitsDefault  = 8;
  localparam int StackDepthDefault = 4;
  localparam int NumW              = 32;

  typedef logic signed [NumW-1:0] num_t;
  typedef logic [$clog2(StackDepthDefault+1)-1:0] depth_t;

  typedef enum logic [4:0] {
    BTN_0, BTN_1, BTN_2, BTN_3, BTN_4,
    BTN_5, BTN_6, BTN_7, BTN_8, BTN_9,
    BTN_ADD, BTN_SUB, BTN_MUL, BTN_DIV,
    BTN_CLEAR, BTN_ENTER, BTN_DROP, BTN_SWAP
  } active_button_t;

  typedef enum logic [1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV
  } op_t;

  typedef enum logic [1:0] {
    IDLE, ALU_REQ, ALU_WAIT, ERROR
  } rpn_state_e;

  function automatic op_t button_to_op(input active_button_t b);
    op_t op;
    case (b)
      BTN_SUB: op = OP_SUB;
      BTN_MUL: op = OP_MUL;
      BTN_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  function automatic logic is_digit(input active_button_t b);
    return (b <= BTN_9);
  endfunction

endpackage

// File: rtl/num_stack.sv
// num_stack: flop-array LIFO of num_t words, entry 0 is the top.
//   clk, rst_n        clock, asynchronous active-low reset (occupancy only)
//   push, push_data   push one word
//   pop               drop the top word
//   pop2              drop the top two words
//   swap              exchange the top two words
//   clear             empty the stack
//   top/second/third  the three uppermost words, 0 where not occupied
//   depth             current occupancy
// Illegal requests (push when full, pop when empty) are not checked here;
// the controller never issues them. Only one control is expected per cycle.
module num_stack
  import calc_pkg::*;
#(
  parameter int Depth = StackDepthDefault
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  num_t                       push_data,
  input  logic                       pop,
  input  logic                       pop2,
  input  logic                       swap,
  input  logic                       clear,
  output num_t                       top,
  output num_t                       second,
  output num_t                       third,
  output logic [$clog2(Depth+1)-1:0] depth
);

  localparam int DepthW = $clog2(Depth+1);

  num_t mem [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (clear) begin
      depth <= '0;
    end else if (push) begin
      depth <= depth + DepthW'(1);
    end else if (pop) begin
      depth <= depth - DepthW'(1);
    end else if (pop2) begin
      depth <= depth - DepthW'(2);
    end
  end

  // Word storage carries no reset: unoccupied slots are masked on the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[0] <= push_data;
      for (int i = 1; i < Depth; i++) mem[i] <= mem[i-1];
    end else if (pop) begin
      for (int i = 0; i < Depth - 1; i++) mem[i] <= mem[i+1];
      mem[Depth-1] <= '0;
    end else if (pop2) begin
      for (int i = 0; i < Depth - 2; i++) mem[i] <= mem[i+2];
      mem[Depth-2] <= '0;
      mem[Depth-1] <= '0;
    end else if (swap) begin
      mem[0] <= mem[1];
      mem[1] <= mem[0];
    end
  end

  assign top    = (depth >= DepthW'(1)) ? mem[0] : '0;
  assign second = (depth >= DepthW'(2)) ? mem[1] : '0;

  generate
    if (Depth >= 3) begin : g_third
      assign third = (depth >= DepthW'(3)) ? mem[2] : '0;
    end else begin : g_no_third
      assign third = '0;
    end
  endgenerate

endmodule

// File: rtl/rpn_calculator.sv
// rpn_calculator: reverse-Polish calculator controller and operand stack.
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   active_button_i, new_input_i     debounced button code and press strobe
//   display_o                        entry while typing, else top of stack
//   depth_o                          stack occupancy
//   busy_o                           ALU operation in flight
//   error_o                          overflow/underflow, cleared by CLEAR
//   alu_left_o/right_o/op_o          ALU operands and operation
//   alu_in_valid_o, alu_in_ready_i   ALU request handshake
//   alu_result_i, alu_out_valid_i,
//   alu_out_ready_o                  ALU response handshake
// Every output is a flop (depth_o is the stack's occupancy register), so the
// next display value is predicted from the action taken this cycle.
module rpn_calculator
  import calc_pkg::*;
#(
  parameter int NumDigits  = NumDigitsDefault,
  parameter int StackDepth = StackDepthDefault
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  active_button_t                  active_button_i,
  input  logic                            new_input_i,
  output num_t                            display_o,
  output logic [$clog2(StackDepth+1)-1:0] depth_o,
  output logic                            busy_o,
  output logic                            error_o,
  output num_t                            alu_left_o,
  output num_t                            alu_right_o,
  output op_t                             alu_op_o,
  output logic                            alu_in_valid_o,
  input  logic                            alu_in_ready_i,
  input  num_t                            alu_result_i,
  input  logic                            alu_out_valid_i,
  output logic                            alu_out_ready_o
);

  localparam int DepthW = $clog2(StackDepth+1);
  localparam int CountW = $clog2(NumDigits+1);
  localparam logic [DepthW-1:0] Full = DepthW'(StackDepth);

  rpn_state_e        state, state_next;
  logic [NumW-1:0]   entry, entry_next;
  logic [CountW-1:0] count, count_next;
  logic              entering, entering_next;
  num_t              display_next, left_next, right_next;
  op_t               op_next;

  logic              st_push, st_pop, st_pop2, st_swap, st_clear;
  num_t              st_data, top, second, third;
  logic [DepthW-1:0] depth;

  logic [4:0]        btn_code;
  logic [NumW-1:0]   digit;

  assign btn_code = active_button_i;
  assign digit    = NumW'(btn_code[3:0]);
  assign depth_o  = depth;

  num_stack #(
    .Depth(StackDepth)
  ) u_stack (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (st_push),
    .push_data(st_data),
    .pop      (st_pop),
    .pop2     (st_pop2),
    .swap     (st_swap),
    .clear    (st_clear),
    .top      (top),
    .second   (second),
    .third    (third),
    .depth    (depth)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next    = state;
    entry_next    = entry;
    count_next    = count;
    entering_next = entering;
    display_next  = display_o;
    left_next     = alu_left_o;
    right_next    = alu_right_o;
    op_next       = alu_op_o;
    st_push       = 1'b0;
    st_pop        = 1'b0;
    st_pop2       = 1'b0;
    st_swap       = 1'b0;
    st_clear      = 1'b0;
    st_data       = '0;

    case (state)
      IDLE: begin
        if (new_input_i) begin
          if (is_digit(active_button_i)) begin
            if (!entering) begin
              entry_next    = digit;
              count_next    = CountW'(1);
              entering_next = 1'b1;
              display_next  = digit;
            end else if (count < CountW'(NumDigits)) begin
              entry_next   = entry * NumW'(10) + digit;
              count_next   = count + CountW'(1);
              display_next = entry_next;
            end
          end else begin
            case (active_button_i)
              BTN_ENTER: begin
                if (entering) begin
                  if (depth == Full) begin
                    state_next = ERROR;
                  end else begin
                    st_push       = 1'b1;
                    st_data       = entry;
                    entering_next = 1'b0;
                    display_next  = entry;
                  end
                end else if (depth != '0) begin
                  if (depth == Full) begin
                    state_next = ERROR;
                  end else begin
                    st_push = 1'b1;
                    st_data = top;
                  end
                end
              end

              BTN_ADD, BTN_SUB, BTN_MUL, BTN_DIV: begin
                if (entering) begin
                  // Implicit push of the entry followed by popping two words
                  // nets out to a single pop with the entry as right operand.
                  if (depth == Full) begin
                    state_next = ERROR;
                  end else if (depth == '0) begin
                    st_push       = 1'b1;
                    st_data       = entry;
                    entering_next = 1'b0;
                    display_next  = entry;
                    state_next    = ERROR;
                  end else begin
                    st_pop        = 1'b1;
                    left_next     = top;
                    right_next    = entry;
                    op_next       = button_to_op(active_button_i);
                    entering_next = 1'b0;
                    display_next  = second;
                    state_next    = ALU_REQ;
                  end
                end else if (depth < DepthW'(2)) begin
                  state_next = ERROR;
                end else begin
                  st_pop2      = 1'b1;
                  left_next    = second;
                  right_next   = top;
                  op_next      = button_to_op(active_button_i);
                  display_next = third;
                  state_next   = ALU_REQ;
                end
              end

              BTN_DROP: begin
                entering_next = 1'b0;
                st_pop        = (depth != '0);
                display_next  = second;
              end

              BTN_SWAP: begin
                if (depth >= DepthW'(2)) begin
                  st_swap = 1'b1;
                  if (!entering) display_next = second;
                end
              end

              BTN_CLEAR: begin
                st_clear      = 1'b1;
                entry_next    = '0;
                count_next    = '0;
                entering_next = 1'b0;
                display_next  = '0;
              end

              default: ;
            endcase
          end
        end
      end

      ALU_REQ: begin
        if (alu_in_ready_i) state_next = ALU_WAIT;
      end

      ALU_WAIT: begin
        if (alu_out_valid_i) begin
          st_push      = 1'b1;
          st_data      = alu_result_i;
          display_next = alu_result_i;
          state_next   = IDLE;
        end
      end

      ERROR: begin
        if (new_input_i && (active_button_i == BTN_CLEAR)) begin
          st_clear      = 1'b1;
          entry_next    = '0;
          count_next    = '0;
          entering_next = 1'b0;
          display_next  = '0;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry           <= '0;
      count           <= '0;
      entering        <= 1'b0;
      display_o       <= '0;
      alu_left_o      <= '0;
      alu_right_o     <= '0;
      alu_op_o        <= OP_ADD;
      busy_o          <= 1'b0;
      error_o         <= 1'b0;
      alu_in_valid_o  <= 1'b0;
      alu_out_ready_o <= 1'b0;
    end else begin
      entry           <= entry_next;
      count           <= count_next;
      entering        <= entering_next;
      display_o       <= display_next;
      alu_left_o      <= left_next;
      alu_right_o     <= right_next;
      alu_op_o        <= op_next;
      busy_o          <= (state_next == ALU_REQ) || (state_next == ALU_WAIT);
      error_o         <= (state_next == ERROR);
      alu_in_valid_o  <= (state_next == ALU_REQ);
      alu_out_ready_o <= (state_next == ALU_WAIT);
    end
  end

endmodule

// File: tb/tb_rpn_calculator.sv
// tb_rpn_calculator: directed bench for rpn_calculator; the bench plays the
// role of the button sanitiser and of the ALU.
module tb_rpn_calculator;
  import calc_pkg::*;

  logic           clk;
  logic           rst_ni;
  active_button_t btn;
  logic           new_input;
  num_t           display;
  logic [2:0]     depth;
  logic           busy, error;
  num_t           alu_left, alu_right, alu_result;
  op_t            alu_op;
  logic           alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  rpn_calculator #(
    .NumDigits (8),
    .StackDepth(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .active_button_i(btn),
    .new_input_i    (new_input),
    .display_o      (display),
    .depth_o        (depth),
    .busy_o         (busy),
    .error_o        (error),
    .alu_left_o     (alu_left),
    .alu_right_o    (alu_right),
    .alu_op_o       (alu_op),
    .alu_in_valid_o (alu_in_valid),
    .alu_in_ready_i (alu_in_ready),
    .alu_result_i   (alu_result),
    .alu_out_valid_i(alu_out_valid),
    .alu_out_ready_o(alu_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input active_button_t b);
    @(negedge clk);
    btn       = b;
    new_input = 1'b1;
    @(negedge clk);
    new_input = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Accept the pending request, then return a result one cycle later.
  task automatic alu_respond(input num_t result);
    alu_in_ready = 1'b1;
    @(negedge clk);
    alu_in_ready = 1'b0;
    alu_out_valid = 1'b1;
    alu_result    = result;
    @(negedge clk);
    alu_out_valid = 1'b0;
    alu_result    = '0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    btn           = BTN_0;
    new_input     = 1'b0;
    alu_in_ready  = 1'b0;
    alu_result    = '0;
    alu_out_valid = 1'b0;

    idle_cycles(2);
    chk("rst_display", display, 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_in_valid", 32'(alu_in_valid), 0);
    chk("rst_out_ready", 32'(alu_out_ready), 0);
    chk("rst_left", alu_left, 0);
    chk("rst_right", alu_right, 0);
    chk("rst_op", 32'(alu_op), 0);
    rst_ni = 1'b1;
    idle_cycles(1);

    // 3 ENTER 4 ADD -> 7
    press(BTN_3);
    chk("t1_entry3", display, 3);
    chk("t1_depth0", 32'(depth), 0);
    press(BTN_ENTER);
    chk("t1_enter_disp", display, 3);
    chk("t1_enter_depth", 32'(depth), 1);
    press(BTN_4);
    chk("t1_entry4", display, 4);
    press(BTN_ADD);
    chk("t1_in_valid", 32'(alu_in_valid), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_left", alu_left, 3);
    chk("t1_right", alu_right, 4);
    chk("t1_op", 32'(alu_op), 32'(OP_ADD));
    chk("t1_depth_popped", 32'(depth), 0);
    alu_respond(32'sd7);
    chk("t1_result_disp", display, 7);
    chk("t1_result_depth", 32'(depth), 1);
    chk("t1_result_busy", 32'(busy), 0);
    chk("t1_result_ready", 32'(alu_out_ready), 0);

    // Nine 9s: the ninth is ignored.
    press(BTN_CLEAR);
    chk("t2_clear_depth", 32'(depth), 0);
    for (int i = 0; i < 9; i++) press(BTN_9);
    chk("t2_max_digits", display, 32'd99999999);

    // Overflow at depth 4.
    press(BTN_CLEAR);
    press(BTN_1); press(BTN_ENTER);
    press(BTN_2); press(BTN_ENTER);
    press(BTN_3); press(BTN_ENTER);
    press(BTN_4); press(BTN_ENTER);
    chk("t3_full_depth", 32'(depth), 4);
    chk("t3_full_disp", display, 4);
    press(BTN_5);
    chk("t3_entry5", display, 5);
    press(BTN_ENTER);
    chk("t3_ovf_error", 32'(error), 1);
    chk("t3_ovf_depth", 32'(depth), 4);
    press(BTN_6);
    chk("t3_err_digit_ignored", display, 5);
    chk("t3_err_sticky", 32'(error), 1);
    press(BTN_CLEAR);
    chk("t3_clr_depth", 32'(depth), 0);
    chk("t3_clr_error", 32'(error), 0);
    chk("t3_clr_disp", display, 0);

    // Underflow: 5 SUB on an empty stack.
    press(BTN_5);
    press(BTN_SUB);
    chk("t4_uf_error", 32'(error), 1);
    chk("t4_uf_no_req", 32'(alu_in_valid), 0);
    chk("t4_uf_busy", 32'(busy), 0);
    chk("t4_uf_depth", 32'(depth), 1);
    press(BTN_CLEAR);
    chk("t4_clr_error", 32'(error), 0);

    // Held request: presses dropped, operands stable.
    press(BTN_8); press(BTN_ENTER);
    press(BTN_2);
    press(BTN_SUB);
    chk("t5_in_valid", 32'(alu_in_valid), 1);
    idle_cycles(3);
    press(BTN_7);
    press(BTN_CLEAR);
    idle_cycles(3);
    chk("t5_hold_valid", 32'(alu_in_valid), 1);
    chk("t5_hold_left", alu_left, 8);
    chk("t5_hold_right", alu_right, 2);
    chk("t5_hold_op", 32'(alu_op), 32'(OP_SUB));
    chk("t5_hold_disp", display, 0);
    chk("t5_hold_depth", 32'(depth), 0);
    chk("t5_hold_busy", 32'(busy), 1);
    alu_in_ready = 1'b1;
    @(negedge clk);
    alu_in_ready = 1'b0;
    chk("t5_wait_valid", 32'(alu_in_valid), 0);
    chk("t5_wait_ready", 32'(alu_out_ready), 1);
    alu_out_valid = 1'b1;
    alu_result    = 32'sd6;
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("t5_result_disp", display, 6);
    chk("t5_result_depth", 32'(depth), 1);
    chk("t5_result_busy", 32'(busy), 0);

    // Two-pop operator, then SWAP, DROP and duplicate.
    press(BTN_9); press(BTN_ENTER);
    press(BTN_3); press(BTN_ENTER);
    chk("t6_depth3", 32'(depth), 3);
    press(BTN_MUL);
    chk("t6_left", alu_left, 9);
    chk("t6_right", alu_right, 3);
    chk("t6_op", 32'(alu_op), 32'(OP_MUL));
    chk("t6_disp_third", display, 6);
    chk("t6_depth1", 32'(depth), 1);
    alu_respond(32'sd27);
    chk("t6_result_disp", display, 27);
    chk("t6_result_depth", 32'(depth), 2);
    press(BTN_SWAP);
    chk("t6_swap_disp", display, 6);
    press(BTN_DROP);
    chk("t6_drop_disp", display, 27);
    chk("t6_drop_depth", 32'(depth), 1);
    press(BTN_ENTER);
    chk("t6_dup_depth", 32'(depth), 2);
    chk("t6_dup_disp", display, 27);

    // Reset while waiting for the result.
    press(BTN_ADD);
    chk("t7_left", alu_left, 27);
    alu_in_ready = 1'b1;
    @(negedge clk);
    alu_in_ready = 1'b0;
    chk("t7_in_wait", 32'(alu_out_ready), 1);
    rst_ni = 1'b0;
    #1;
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_ready", 32'(alu_out_ready), 0);
    chk("t7_rst_depth", 32'(depth), 0);
    chk("t7_rst_disp", display, 0);
    chk("t7_rst_left", alu_left, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    press(BTN_4);
    chk("t7_idle_entry", display, 4);
    chk("t7_idle_error", 32'(error), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
